// File: rtl/stage_loader_pkg.sv
// Shared constants and FSM state encoding for the stage loader.
// Brick rows are ROW_W bits wide: BRICKS_PER_ROW fields of BRICK_W bits,
// brick 0 in the most significant field.
package stage_loader_pkg;

  localparam int BRICKS_PER_ROW = 10;
  localparam int BRICK_W        = 3;
  localparam int ROW_W          = 30;
  localparam int STAGE_ROWS     = 30;

  localparam logic [BRICK_W-1:0] BRICK_EMPTY = 3'b000;
  localparam logic [BRICK_W-1:0] BRICK_SOLID = 3'b111;

  // Loader FSM state type and encodings
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/stage_loader_brick_row_counter.sv
// brick_row_counter: combinational count (0..10) of breakable bricks in one
// stage row. Empty (000) and solid (111) fields are not breakable.
module brick_row_counter
  import stage_loader_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  output logic [3:0]       count
);

  logic [BRICKS_PER_ROW-1:0] breakable;

  genvar gi;
  generate
    for (gi = 0; gi < BRICKS_PER_ROW; gi++) begin : g_brick
      logic [BRICK_W-1:0] field;
      assign field         = row[ROW_W-1-gi*BRICK_W -: BRICK_W];
      assign breakable[gi] = (field != BRICK_EMPTY) && (field != BRICK_SOLID);
    end
  endgenerate

  // Population count of the per-brick breakable flags
  always_comb begin
    count = '0;
    for (int i = 0; i < BRICKS_PER_ROW; i++) begin
      count = count + 4'(breakable[i]);
    end
  end

endmodule

// File: rtl/stage_loader.sv
// stage_loader: copies ROWS rows of a stage ROM into the brick map.
// One ROM read per cycle in FETCH; each row is written to the map the cycle
// after its read, so the last write lands in DRAIN. DONE pulses done.
// Optional macro STAGE_LOADER_COUNT_EN enables the breakable-brick counter;
// without it brick_count is tied to 0.
module stage_loader
  import stage_loader_pkg::*;
#(
  parameter int ROWS = STAGE_ROWS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       stage,
  output logic             rom_enable,
  output logic [1:0]       rom_stage,
  output logic [4:0]       rom_addr,
  input  logic [ROW_W-1:0] rom_data,
  output logic             map_we,
  output logic [4:0]       map_row,
  output logic [ROW_W-1:0] map_data,
  output logic             busy,
  output logic             done,
  output logic [8:0]       brick_count
);

  localparam logic [4:0] LAST_ADDR = 5'(ROWS - 1);

  state_t     state_reg;
  logic [4:0] addr_reg;
  logic [1:0] stage_reg;
  logic       map_we_reg;
  logic [4:0] map_row_reg;
  logic       accept;

  assign accept = (state_reg == ST_IDLE) && start;

  // FSM, ROM address sequencing and stage latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      stage_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_FETCH;
            stage_reg <= stage;
            addr_reg  <= '0;
          end
        end
        ST_FETCH: begin
          if (addr_reg == LAST_ADDR) begin
            state_reg <= ST_DRAIN;
            addr_reg  <= '0;
          end else begin
            addr_reg <= addr_reg + 5'd1;
          end
        end
        ST_DRAIN: state_reg <= ST_DONE;
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Map write strobe and row index trail the ROM read by one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_we_reg  <= 1'b0;
      map_row_reg <= '0;
    end else begin
      map_we_reg  <= rom_enable;
      map_row_reg <= rom_enable ? rom_addr : 5'd0;
    end
  end

  assign rom_enable = (state_reg == ST_FETCH);
  assign rom_addr   = addr_reg;
  assign rom_stage  = stage_reg;
  assign map_we     = map_we_reg;
  assign map_row    = map_row_reg;
  // ROM data arrives exactly in the write cycle, so pass it straight through
  assign map_data   = map_we_reg ? rom_data : '0;
  assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign done       = (state_reg == ST_DONE);

`ifdef STAGE_LOADER_COUNT_EN
  logic [3:0] row_count;
  logic [8:0] count_reg;

  brick_row_counter u_row_counter (
    .row   (rom_data),
    .count (row_count)
  );

  // Running breakable-brick total: cleared on accept, accumulated per write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= '0;
    end else if (map_we_reg) begin
      count_reg <= count_reg + 9'(row_count);
    end
  end

  assign brick_count = count_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign brick_count   = '0;
`endif

endmodule
